alu_framer: RTL and testbench

Parametrised result framer placed between the ALU result port (`alu_ready`/`alu_result`) and the frame output interface. Buffers ALU results in a DEPTH-entry FIFO and emits them as frames of programmable length, with SOP/EOP marking and backpressure. Results that arrive while the FIFO is full are dropped and counted. This supersedes the tied-off `frame_len`/`frame_len_val` usage with a real length-programmable framing path.

---
 rtl/alu_framer_if.sv | 31 +++
 rtl/alu_framer.sv | 160 ++++++++++++++++
 tb/tb_alu_framer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_framer_if.sv
// Bus bundle between the ALU result port, the frame output and the framer status.
// master drives results, length control and backpressure; slave is the framer.
interface alu_framer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LEN_W  = 5
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              res_val;
  logic [DATA_W-1:0] res_data;
  logic [LEN_W-1:0]  frame_len;
  logic              frame_len_val;
  logic              frame_bp;
  logic              frame;
  logic              frame_sop;
  logic              frame_eop;
  logic [DATA_W-1:0] frame_data;
  logic [LVL_W-1:0]  fifo_level;
  logic [7:0]        drop_cnt;

  modport master (
    output res_val, res_data, frame_len, frame_len_val, frame_bp,
    input  frame, frame_sop, frame_eop, frame_data, fifo_level, drop_cnt
  );

  modport slave (
    input  res_val, res_data, frame_len, frame_len_val, frame_bp,
    output frame, frame_sop, frame_eop, frame_data, fifo_level, drop_cnt
  );
endinterface

// File: rtl/alu_framer.sv
// Buffers ALU results in a small FIFO and emits them as SOP/EOP-marked frames
// of programmable length; overflowing results are dropped and counted.
module alu_framer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LEN_W  = 5
) (
  input logic         clk,
  input logic         rst_n,
  alu_framer_if.slave io_bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;
  localparam int unsigned CNT_W = LEN_W + 1;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] LEN_MAX  = {1'b1, {LEN_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       DROP_SAT = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [7:0]        r_drop_cnt;
  logic [LEN_W-1:0]  r_len_q;
  state_t            r_state;
  logic [CNT_W-1:0]  r_bcnt;
  logic [CNT_W-1:0]  r_cur_len;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_drop;
  logic              w_beat;
  logic [CNT_W-1:0]  w_eff_len;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_bcnt_nxt;
  logic [CNT_W-1:0]  w_cur_len_nxt;
  logic              w_sop;
  logic              w_eop;

  // A full FIFO drops the incoming result even when a pop frees a slot this cycle.
  assign w_full    = (r_level == LVL_FULL);
  assign w_empty   = (r_level == '0);
  assign w_push    = io_bus.res_val & ~w_full;
  assign w_drop    = io_bus.res_val & w_full;
  assign w_beat    = ~w_empty & ~io_bus.frame_bp;
  assign w_eff_len = (r_len_q == '0) ? LEN_MAX : CNT_W'(r_len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= io_bus.res_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_beat) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_beat})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != DROP_SAT)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_q <= LEN_W'(1);
    end else if (io_bus.frame_len_val) begin
      r_len_q <= io_bus.frame_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bcnt    <= '0;
      r_cur_len <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_cur_len <= w_cur_len_nxt;
    end
  end

  // Frame sequencing; the open frame keeps its latched length across len_q updates.
  always_comb begin
    w_state_nxt   = r_state;
    w_bcnt_nxt    = r_bcnt;
    w_cur_len_nxt = r_cur_len;
    w_sop         = 1'b0;
    w_eop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          w_sop         = 1'b1;
          w_cur_len_nxt = w_eff_len;
          if (w_eff_len == CNT_ONE) begin
            w_eop = 1'b1;
          end else begin
            w_bcnt_nxt  = CNT_ONE;
            w_state_nxt = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        if (w_beat) begin
          if (r_bcnt == (r_cur_len - CNT_ONE)) begin
            w_eop       = 1'b1;
            w_bcnt_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_bcnt_nxt = r_bcnt + CNT_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_bcnt_nxt  = '0;
      end
    endcase
  end

  assign io_bus.frame      = w_beat;
  assign io_bus.frame_sop  = w_sop;
  assign io_bus.frame_eop  = w_eop;
  assign io_bus.frame_data = r_mem[r_rd_ptr];
  assign io_bus.fifo_level = r_level;
  assign io_bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_alu_framer.sv
// Directed and randomized bench for alu_framer, checked against a queue-based
// model of the FIFO and of frame boundaries.
module tb_alu_framer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned LEN_W  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_framer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

  alu_framer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  // Reference state: queued results, programmed length, open frame length and
  // beats already emitted in it (0 = no frame open), and dropped results.
  logic [31:0] m_q[$];
  int          m_len;
  int          m_cur;
  int          m_pos;
  int          m_drops;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_len   = 1;
    m_cur   = 0;
    m_pos   = 0;
    m_drops = 0;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model and the DUT.
  task automatic step(input logic v, input logic [31:0] d, input logic bp,
                      input logic lv, input logic [4:0] ln);
    int   sz;
    int   eff;
    logic e_beat;
    logic e_sop;
    logic e_eop;
    bus.res_val       = v;
    bus.res_data      = d;
    bus.frame_bp      = bp;
    bus.frame_len_val = lv;
    bus.frame_len     = ln;
    #1;
    sz     = m_q.size();
    eff    = (m_len == 0) ? 32 : m_len;
    e_beat = (sz != 0) && !bp;
    e_sop  = e_beat && (m_pos == 0);
    e_eop  = e_beat && ((m_pos == 0) ? (eff == 1) : (m_pos + 1 == m_cur));
    chk("frame", 32'(bus.frame), 32'(e_beat));
    chk("sop",   32'(bus.frame_sop), 32'(e_sop));
    chk("eop",   32'(bus.frame_eop), 32'(e_eop));
    chk("level", 32'(bus.fifo_level), 32'(sz));
    chk("drops", 32'(bus.drop_cnt), 32'(m_drops));
    if (e_beat) begin
      chk("data", bus.frame_data, m_q[0]);
      void'(m_q.pop_front());
      if (m_pos == 0) begin
        m_cur = eff;
        m_pos = (eff == 1) ? 0 : 1;
      end else begin
        m_pos = (m_pos + 1 == m_cur) ? 0 : m_pos + 1;
      end
    end
    if (v) begin
      if (sz == DEPTH) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
      else             m_q.push_back(d);
    end
    if (lv) m_len = int'(ln);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input int n, input logic bp);
    for (int i = 0; i < n; i++) step(1'b1, $urandom, bp, 1'b0, 5'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic load_len(input logic [4:0] ln);
    step(1'b0, 32'd0, 1'b0, 1'b1, ln);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_frame"}, 32'(bus.frame), 32'd0);
    chk({tag, "_sop"},   32'(bus.frame_sop), 32'd0);
    chk({tag, "_eop"},   32'(bus.frame_eop), 32'd0);
    chk({tag, "_level"}, 32'(bus.fifo_level), 32'd0);
    chk({tag, "_drops"}, 32'(bus.drop_cnt), 32'd0);
    chk({tag, "_data"},  bus.frame_data, 32'd0);
  endtask

  initial begin
    bus.res_val       = 1'b0;
    bus.res_data      = '0;
    bus.frame_bp      = 1'b0;
    bus.frame_len_val = 1'b0;
    bus.frame_len     = '0;
    model_reset();

    // Reset defaults, then three single-beat frames at the reset length of 1
    @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    push(3, 1'b0);
    idle(3);

    // 4-beat frames on a continuous stream
    load_len(5'd4);
    push(8, 1'b0);
    idle(3);

    // Gap inside an open frame
    push(2, 1'b0);
    idle(5);
    push(2, 1'b0);
    idle(3);

    // Overflow under backpressure, then drain
    push(11, 1'b1);
    #1;
    chk("ovf_level", 32'(bus.fifo_level), 32'd8);
    chk("ovf_drops", 32'(bus.drop_cnt), 32'd3);
    idle(10);
    for (int r = 0; r < 6; r++) begin
      push(60, 1'b1);
      idle(10);
    end
    #1;
    chk("drop_sat", 32'(bus.drop_cnt), 32'd255);

    // Length change mid-frame, then encoded zero (32 beats)
    load_len(5'd4);
    push(2, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b1, 5'd2);
    push(3, 1'b0);
    idle(4);
    load_len(5'd0);
    push(64, 1'b0);
    idle(10);

    // Reset in the middle of an 8-beat frame
    load_len(5'd8);
    push(5, 1'b1);
    idle(3);
    bus.res_val  = 1'b0;
    bus.frame_bp = 1'b0;
    rst_n        = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    push(1, 1'b0);
    idle(2);

    // Randomized traffic with occasional length loads and backpressure
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, 5'($urandom_range(0, 6)));
    end
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
